tile_rom_fetch_arb: RTL and testbench



---
 rtl/tile_fetch_pkg.sv | 45 ++++
 rtl/tile_fetch_cache.sv | 66 ++++++
 rtl/tile_rom_fetch_arb.sv | 210 +++++++++++++++++++++
 tb/tb_tile_rom_fetch_arb.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_fetch_pkg.sv
// -----------------------------------------------------------------------------
// tile_fetch_pkg
// Shared definitions for the tile-layer ROM fetch arbiter:
//   - fetch_state_e : arbiter FSM states
//   - NCH_MAX       : largest supported requester count
//   - rr_pick()     : round-robin "first pending channel at or after start"
// -----------------------------------------------------------------------------
package tile_fetch_pkg;

  localparam int NCH_MAX = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DELIVER = 2'd2
  } fetch_state_e;

  // Returns {found, index}. The search runs start, start+1, ... modulo nch,
  // so the channel at 'start' has the highest priority.
  function automatic logic [3:0] rr_pick(input logic [NCH_MAX-1:0] pend,
                                         input logic [2:0]         start,
                                         input logic [3:0]         nch);
    logic       found;
    logic [2:0] idx;
    logic [4:0] cand;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 0; k < NCH_MAX; k++) begin
      cand = 5'(start) + 5'(k);
      if (cand >= 5'(nch)) begin
        cand = cand - 5'(nch);
      end else begin
        cand = cand;
      end
      if (!found && (5'(k) < 5'(nch)) && pend[cand[2:0]]) begin
        found = 1'b1;
        idx   = cand[2:0];
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/tile_fetch_cache.sv
// -----------------------------------------------------------------------------
// tile_fetch_cache
// Per-channel store of the last ROM fetch (address, data, valid) with a
// combinational hit compare for the channel currently being granted.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset (clears valid)
//   i_lookup_idx/addr   : channel and address being granted
//   o_hit, o_hit_data   : stored entry matches / its data
//   i_wr_en/idx/addr/data : update entry after a completed ROM fetch
// -----------------------------------------------------------------------------
module tile_fetch_cache #(
  parameter int NCH    = 4,
  parameter int ADDR_W = 22,
  parameter int DATA_W = 64,
  parameter int IDXW   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IDXW-1:0]   i_lookup_idx,
  input  logic [ADDR_W-1:0] i_lookup_addr,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_hit_data,
  input  logic              i_wr_en,
  input  logic [IDXW-1:0]   i_wr_idx,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data
);

  logic [ADDR_W-1:0] r_addr [NCH];
  logic [DATA_W-1:0] r_data [NCH];
  logic [NCH-1:0]    r_valid;

  // Entry storage: written only when a ROM fetch completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else if (i_wr_en) begin
      for (int i = 0; i < NCH; i++) begin
        if (IDXW'(i) == i_wr_idx) begin
          r_addr[i]  <= i_wr_addr;
          r_data[i]  <= i_wr_data;
          r_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Hit compare for the granted channel.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (IDXW'(i) == i_lookup_idx) begin
        o_hit      = r_valid[i] && (r_addr[i] == i_lookup_addr);
        o_hit_data = r_data[i];
      end else begin
        o_hit = o_hit;
      end
    end
  end

endmodule

// File: rtl/tile_rom_fetch_arb.sv
// -----------------------------------------------------------------------------
// tile_rom_fetch_arb
// Round-robin arbiter between NCH tile-layer fetch requesters (toggle
// handshake) and one shared graphics-ROM port (toggle handshake). Blank tiles
// are answered without touching the ROM. Data is delivered through a
// registered one-hot load strobe plus channel index.
// Optional feature, macro TILE_ROM_FETCH_CACHE_EN: per-channel last-fetch
// cache; a repeated address on the same channel skips the ROM.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   ch_req/ch_ack           : per-channel request/acknowledge toggles
//   ch_addr, ch_blank       : per-channel address and blank flag
//   rom_address/req/ack/data: ROM controller port
//   load, load_index, load_data : one-cycle data-valid strobe and payload
// -----------------------------------------------------------------------------
module tile_rom_fetch_arb
  import tile_fetch_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int ADDR_W = 22,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NCH-1:0]           ch_req,
  output logic [NCH-1:0]           ch_ack,
  input  logic [NCH*ADDR_W-1:0]    ch_addr,
  input  logic [NCH-1:0]           ch_blank,
  output logic [ADDR_W-1:0]        rom_address,
  output logic                     rom_req,
  input  logic                     rom_ack,
  input  logic [DATA_W-1:0]        rom_data,
  output logic [NCH-1:0]           load,
  output logic [$clog2(NCH)-1:0]   load_index,
  output logic [DATA_W-1:0]        load_data
);

  localparam int IDXW = $clog2(NCH);

  fetch_state_e      r_state,       w_state_nxt;
  logic              r_wait_first,  w_wait_first_nxt;
  logic [IDXW-1:0]   r_rr,          w_rr_nxt;
  logic [IDXW-1:0]   r_g,           w_g_nxt;
  logic [NCH-1:0]    r_ch_ack,      w_ch_ack_nxt;
  logic              r_rom_req,     w_rom_req_nxt;
  logic [ADDR_W-1:0] r_rom_address, w_rom_address_nxt;
  logic [NCH-1:0]    r_load,        w_load_nxt;
  logic [IDXW-1:0]   r_load_index,  w_load_index_nxt;
  logic [DATA_W-1:0] r_load_data,   w_load_data_nxt;

  logic [NCH-1:0]     w_pend;
  logic [NCH_MAX-1:0] w_pend_pad;
  logic [3:0]         w_pick;
  logic               w_pick_found;
  logic [IDXW-1:0]    w_pick_idx;
  logic [ADDR_W-1:0]  w_gaddr;
  logic               w_hit;
  logic [DATA_W-1:0]  w_hit_data;

  function automatic logic [IDXW-1:0] f_rr_inc(input logic [IDXW-1:0] g);
    if (g == IDXW'(NCH - 1)) begin
      return '0;
    end else begin
      return g + IDXW'(1);
    end
  endfunction

  assign w_pend       = ch_req ^ r_ch_ack;
  assign w_pick       = rr_pick(w_pend_pad, 3'(r_rr), 4'(NCH));
  assign w_pick_found = w_pick[3];
  assign w_pick_idx   = IDXW'(w_pick[2:0]);

  // Widen the pending vector to the search function's fixed width.
  always_comb begin
    w_pend_pad           = '0;
    w_pend_pad[NCH-1:0]  = w_pend;
  end

  // Address of the channel the round-robin search picked.
  always_comb begin
    w_gaddr = '0;
    for (int i = 0; i < NCH; i++) begin
      if (IDXW'(i) == w_pick_idx) begin
        w_gaddr = ch_addr[i*ADDR_W +: ADDR_W];
      end else begin
        w_gaddr = w_gaddr;
      end
    end
  end

`ifdef TILE_ROM_FETCH_CACHE_EN
  logic w_cache_wr;

  // A ROM fetch completes on the WAIT cycle where the ack is first compared equal.
  assign w_cache_wr = (r_state == S_WAIT) && !r_wait_first && (rom_ack == r_rom_req);

  tile_fetch_cache #(
    .NCH    (NCH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .IDXW   (IDXW)
  ) u_cache (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_lookup_idx  (w_pick_idx),
    .i_lookup_addr (w_gaddr),
    .o_hit         (w_hit),
    .o_hit_data    (w_hit_data),
    .i_wr_en       (w_cache_wr),
    .i_wr_idx      (r_g),
    .i_wr_addr     (r_rom_address),
    .i_wr_data     (rom_data)
  );
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif

  // Next-state and next-output logic for the arbiter FSM.
  always_comb begin
    w_state_nxt       = r_state;
    w_wait_first_nxt  = r_wait_first;
    w_rr_nxt          = r_rr;
    w_g_nxt           = r_g;
    w_ch_ack_nxt      = r_ch_ack;
    w_rom_req_nxt     = r_rom_req;
    w_rom_address_nxt = r_rom_address;
    w_load_nxt        = '0;
    w_load_index_nxt  = r_load_index;
    w_load_data_nxt   = r_load_data;
    case (r_state)
      S_IDLE: begin
        if (w_pick_found) begin
          if (ch_blank[w_pick_idx] || w_hit) begin
            // Blank tile (or cached row): answer immediately, no ROM access.
            w_load_data_nxt          = ch_blank[w_pick_idx] ? '0 : w_hit_data;
            w_load_nxt[w_pick_idx]   = 1'b1;
            w_load_index_nxt         = w_pick_idx;
            w_ch_ack_nxt[w_pick_idx] = ch_req[w_pick_idx];
            w_rr_nxt                 = f_rr_inc(w_pick_idx);
          end else begin
            w_rom_address_nxt = w_gaddr;
            w_rom_req_nxt     = ~r_rom_req;
            w_g_nxt           = w_pick_idx;
            w_wait_first_nxt  = 1'b1;
            w_state_nxt       = S_WAIT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        // rom_ack is ignored in the cycle rom_req changes.
        if (r_wait_first) begin
          w_wait_first_nxt = 1'b0;
        end else if (rom_ack == r_rom_req) begin
          w_load_data_nxt = rom_data;
          w_state_nxt     = S_DELIVER;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DELIVER: begin
        w_load_nxt[r_g]   = 1'b1;
        w_load_index_nxt  = r_g;
        w_ch_ack_nxt[r_g] = ch_req[r_g];
        w_rr_nxt          = f_rr_inc(r_g);
        w_state_nxt       = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_wait_first  <= 1'b0;
      r_rr          <= '0;
      r_g           <= '0;
      r_ch_ack      <= '0;
      r_rom_req     <= 1'b0;
      r_rom_address <= '0;
      r_load        <= '0;
      r_load_index  <= '0;
      r_load_data   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_first  <= w_wait_first_nxt;
      r_rr          <= w_rr_nxt;
      r_g           <= w_g_nxt;
      r_ch_ack      <= w_ch_ack_nxt;
      r_rom_req     <= w_rom_req_nxt;
      r_rom_address <= w_rom_address_nxt;
      r_load        <= w_load_nxt;
      r_load_index  <= w_load_index_nxt;
      r_load_data   <= w_load_data_nxt;
    end
  end

  assign ch_ack      = r_ch_ack;
  assign rom_req     = r_rom_req;
  assign rom_address = r_rom_address;
  assign load        = r_load;
  assign load_index  = r_load_index;
  assign load_data   = r_load_data;

endmodule

// File: tb/tb_tile_rom_fetch_arb.sv
module tb_tile_rom_fetch_arb;
  localparam int AW = 22;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // 4-channel instance
  logic [3:0]      ch_req4, ch_ack4, ch_blank4, load4;
  logic [4*AW-1:0] ch_addr4;
  logic [AW-1:0]   rom_address4;
  logic            rom_req4, rom_ack4;
  logic [DW-1:0]   rom_data4, load_data4;
  logic [1:0]      load_index4;

  // 5-channel instance
  logic [4:0]      ch_req5, ch_ack5, ch_blank5, load5;
  logic [5*AW-1:0] ch_addr5;
  logic [AW-1:0]   rom_address5;
  logic            rom_req5, rom_ack5;
  logic [DW-1:0]   rom_data5, load_data5;
  logic [2:0]      load_index5;

  int errors = 0;
  int checks = 0;
  int rom_delay4 = 3;
  int toggles4 = 0;
  int overlap4 = 0;
  int nload4 = 0;

  tile_rom_fetch_arb #(.NCH(4), .ADDR_W(AW), .DATA_W(DW)) dut4 (
    .clk(clk), .reset_n(reset_n), .ch_req(ch_req4), .ch_ack(ch_ack4),
    .ch_addr(ch_addr4), .ch_blank(ch_blank4), .rom_address(rom_address4),
    .rom_req(rom_req4), .rom_ack(rom_ack4), .rom_data(rom_data4),
    .load(load4), .load_index(load_index4), .load_data(load_data4));

  tile_rom_fetch_arb #(.NCH(5), .ADDR_W(AW), .DATA_W(DW)) dut5 (
    .clk(clk), .reset_n(reset_n), .ch_req(ch_req5), .ch_ack(ch_ack5),
    .ch_addr(ch_addr5), .ch_blank(ch_blank5), .rom_address(rom_address5),
    .rom_req(rom_req5), .rom_ack(rom_ack5), .rom_data(rom_data5),
    .load(load5), .load_index(load_index5), .load_data(load_data5));

  // ROM contents model
  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    if (a == 22'h12340) return 64'hDEADBEEF_01234567;
    return {20'h0, a, ~a};
  endfunction

  // ROM responder for dut4: acks after rom_delay4 cycles
  initial begin : rom_resp4
    int cnt;
    cnt = 0; rom_ack4 = 1'b0; rom_data4 = '0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        rom_ack4 = 1'b0; cnt = 0;
      end else begin
        #1;
        if (rom_req4 !== rom_ack4) begin
          cnt++;
          if (cnt >= rom_delay4) begin
            rom_ack4 = rom_req4; rom_data4 = rom_fn(rom_address4); cnt = 0;
          end
        end else cnt = 0;
      end
    end
  end

  // ROM responder for dut5: acks after 1 cycle
  initial begin : rom_resp5
    rom_ack5 = 1'b0; rom_data5 = '0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) rom_ack5 = 1'b0;
      else begin
        #1;
        if (rom_req5 !== rom_ack5) begin
          rom_ack5 = rom_req5; rom_data5 = rom_fn(rom_address5);
        end
      end
    end
  end

  // Count ROM request toggles and toggles issued while one is still outstanding
  always @(rom_req4) begin
    if (reset_n === 1'b1) begin
      toggles4++;
      if (rom_req4 === rom_ack4) overlap4++;
    end
  end

  always @(negedge clk) if (load4 !== 4'b0) nload4++;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_load4(input int maxc, output logic ok, output int cyc);
    ok = 1'b0; cyc = 0;
    while (cyc < maxc && !ok) begin
      @(negedge clk); cyc++;
      if (load4 !== 4'b0) ok = 1'b1;
    end
  endtask

  task automatic wait_load5(input int maxc, output logic ok);
    int c;
    ok = 1'b0; c = 0;
    while (c < maxc && !ok) begin
      @(negedge clk); c++;
      if (load5 !== 5'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ch_req4 = '0; ch_blank4 = '0; ch_addr4 = '0;
    ch_req5 = '0; ch_blank5 = '0; ch_addr5 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ch_ack4 !== 4'b0) begin errors++; $display("FAIL reset_ch_ack got=%b exp=0", ch_ack4); end
    checks++; if (rom_req4 !== 1'b0) begin errors++; $display("FAIL reset_rom_req got=%b exp=0", rom_req4); end
    checks++; if (rom_address4 !== 22'h0) begin errors++; $display("FAIL reset_rom_address got=%h exp=0", rom_address4); end
    checks++; if (load4 !== 4'b0) begin errors++; $display("FAIL reset_load got=%b exp=0", load4); end
    checks++; if (load_index4 !== 2'd0) begin errors++; $display("FAIL reset_load_index got=%0d exp=0", load_index4); end
    checks++; if (load_data4 !== 64'h0) begin errors++; $display("FAIL reset_load_data got=%h exp=0", load_data4); end
    checks++; if (load5 !== 5'b0 || ch_ack5 !== 5'b0) begin errors++; $display("FAIL reset_nch5 load=%b ack=%b exp=0", load5, ch_ack5); end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    logic ok; int cyc, t0, n0;
    tick();
    ch_addr4[1*AW +: AW] = 22'h12340;
    t0 = toggles4; n0 = nload4;
    ch_req4[1] = ~ch_req4[1];
    wait_load4(30, ok, cyc);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout no load within 30 cycles"); end
    checks++; if (cyc !== 6) begin errors++; $display("FAIL single_latency got=%0d exp=6", cyc); end
    checks++; if (load4 !== 4'b0010) begin errors++; $display("FAIL single_load got=%b exp=0010", load4); end
    checks++; if (load_index4 !== 2'd1) begin errors++; $display("FAIL single_index got=%0d exp=1", load_index4); end
    checks++; if (load_data4 !== 64'hDEADBEEF_01234567) begin errors++; $display("FAIL single_data got=%h exp=deadbeef01234567", load_data4); end
    checks++; if (ch_ack4 !== 4'b0010) begin errors++; $display("FAIL single_ack got=%b exp=0010", ch_ack4); end
    checks++; if (rom_address4 !== 22'h12340) begin errors++; $display("FAIL single_rom_address got=%h exp=12340", rom_address4); end
    checks++; if (toggles4 - t0 !== 1) begin errors++; $display("FAIL single_rom_toggles got=%0d exp=1", toggles4 - t0); end
    repeat (5) @(negedge clk);
    checks++; if (nload4 - n0 !== 1) begin errors++; $display("FAIL single_load_count got=%0d exp=1", nload4 - n0); end
    checks++; if (load_data4 !== 64'hDEADBEEF_01234567) begin errors++; $display("FAIL single_data_hold got=%h exp=deadbeef01234567", load_data4); end
  endtask

  task automatic test_all_four();
    logic ok; int cyc, t0;
    logic [AW-1:0] addr_tab [4];
    int order [4];
    addr_tab = '{22'h20000, 22'h20010, 22'h20020, 22'h20030};
    order = '{2, 3, 0, 1};
    tick();
    for (int i = 0; i < 4; i++) ch_addr4[i*AW +: AW] = addr_tab[i];
    t0 = toggles4; overlap4 = 0;
    ch_req4 = ~ch_req4;
    for (int k = 0; k < 4; k++) begin
      wait_load4(40, ok, cyc);
      checks++; if (!ok) begin errors++; $display("FAIL all4_timeout step=%0d", k); end
      checks++; if (load_index4 !== 2'(order[k]) || load4 !== 4'(1 << order[k])) begin
        errors++; $display("FAIL all4_order step=%0d got idx=%0d load=%b exp idx=%0d", k, load_index4, load4, order[k]); end
      checks++; if (load_data4 !== rom_fn(addr_tab[order[k]])) begin
        errors++; $display("FAIL all4_data step=%0d got=%h exp=%h", k, load_data4, rom_fn(addr_tab[order[k]])); end
    end
    checks++; if (toggles4 - t0 !== 4) begin errors++; $display("FAIL all4_rom_toggles got=%0d exp=4", toggles4 - t0); end
    checks++; if (overlap4 !== 0) begin errors++; $display("FAIL all4_outstanding got=%0d exp=0", overlap4); end
    checks++; if (ch_ack4 !== ch_req4) begin errors++; $display("FAIL all4_ack got=%b exp=%b", ch_ack4, ch_req4); end
  endtask

  // rr is 2 here: ch2 must be served before ch0
  task automatic test_blank();
    logic ok; int cyc, t0;
    tick();
    ch_blank4 = 4'b0101;
    t0 = toggles4;
    ch_req4[0] = ~ch_req4[0];
    ch_req4[2] = ~ch_req4[2];
    wait_load4(10, ok, cyc);
    checks++; if (!ok || cyc !== 2) begin errors++; $display("FAIL blank_latency got=%0d exp=2", cyc); end
    checks++; if (load4 !== 4'b0100 || load_index4 !== 2'd2) begin errors++; $display("FAIL blank_first got load=%b idx=%0d exp 0100/2", load4, load_index4); end
    checks++; if (load_data4 !== 64'h0) begin errors++; $display("FAIL blank_data got=%h exp=0", load_data4); end
    @(negedge clk);
    checks++; if (load4 !== 4'b0001 || load_index4 !== 2'd0) begin errors++; $display("FAIL blank_second got load=%b idx=%0d exp 0001/0", load4, load_index4); end
    checks++; if (toggles4 - t0 !== 0) begin errors++; $display("FAIL blank_rom_toggles got=%0d exp=0", toggles4 - t0); end
    checks++; if (ch_ack4 !== ch_req4) begin errors++; $display("FAIL blank_ack got=%b exp=%b", ch_ack4, ch_req4); end
    ch_blank4 = 4'b0;
  endtask

  // rr is 1 here: ch1, then ch2, then ch1 again (re-request waits)
  task automatic test_back_to_back();
    logic ok; int cyc;
    tick();
    ch_addr4[1*AW +: AW] = 22'h21000;
    ch_addr4[2*AW +: AW] = 22'h22000;
    ch_req4[1] = ~ch_req4[1];
    ch_req4[2] = ~ch_req4[2];
    wait_load4(30, ok, cyc);
    checks++; if (!ok || load_index4 !== 2'd1) begin errors++; $display("FAIL b2b_first got idx=%0d exp=1", load_index4); end
    ch_addr4[1*AW +: AW] = 22'h21100;
    ch_req4[1] = ~ch_req4[1];
    wait_load4(30, ok, cyc);
    checks++; if (!ok || load_index4 !== 2'd2 || load_data4 !== rom_fn(22'h22000)) begin
      errors++; $display("FAIL b2b_second got idx=%0d data=%h exp idx=2", load_index4, load_data4); end
    wait_load4(30, ok, cyc);
    checks++; if (!ok || load_index4 !== 2'd1 || load_data4 !== rom_fn(22'h21100)) begin
      errors++; $display("FAIL b2b_third got idx=%0d data=%h exp idx=1 data=%h", load_index4, load_data4, rom_fn(22'h21100)); end
  endtask

  task automatic test_reset_mid();
    logic ok; int cyc;
    tick();
    rom_delay4 = 50;
    ch_addr4[3*AW +: AW] = 22'h03330;
    ch_req4[3] = ~ch_req4[3];
    repeat (3) @(negedge clk);
    checks++; if (rom_req4 === rom_ack4) begin errors++; $display("FAIL midreset_precond not waiting req=%b ack=%b", rom_req4, rom_ack4); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (rom_req4 !== 1'b0) begin errors++; $display("FAIL midreset_rom_req got=%b exp=0", rom_req4); end
    checks++; if (ch_ack4 !== 4'b0) begin errors++; $display("FAIL midreset_ch_ack got=%b exp=0", ch_ack4); end
    checks++; if (load4 !== 4'b0 || rom_address4 !== 22'h0) begin errors++; $display("FAIL midreset_outputs load=%b addr=%h exp 0/0", load4, rom_address4); end
    ch_req4 = '0; ch_req5 = '0;
    rom_delay4 = 3;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    ch_req4[3] = 1'b1;
    wait_load4(30, ok, cyc);
    checks++; if (!ok || load4 !== 4'b1000 || load_index4 !== 2'd3) begin errors++; $display("FAIL midreset_after got load=%b idx=%0d exp 1000/3", load4, load_index4); end
    checks++; if (load_data4 !== rom_fn(22'h03330) || ch_ack4 !== 4'b1000) begin
      errors++; $display("FAIL midreset_after_data got=%h ack=%b exp=%h ack=1000", load_data4, ch_ack4, rom_fn(22'h03330)); end
  endtask

  task automatic test_wrap5();
    logic ok;
    logic [4:0] masks [4];
    int cnts [4];
    int seq [6];
    int p;
    masks = '{5'b01000, 5'b10001, 5'b10000, 5'b00011};
    cnts  = '{1, 2, 1, 2};
    seq   = '{3, 4, 0, 4, 0, 1};
    p = 0;
    for (int i = 0; i < 5; i++) ch_addr5[i*AW +: AW] = 22'h05000 + 22'(i);
    for (int s = 0; s < 4; s++) begin
      tick();
      ch_req5 = ch_req5 ^ masks[s];
      for (int k = 0; k < cnts[s]; k++) begin
        wait_load5(30, ok);
        checks++; if (!ok || load_index5 !== 3'(seq[p]) || load5 !== 5'(1 << seq[p])) begin
          errors++; $display("FAIL wrap5_order step=%0d got idx=%0d load=%b exp idx=%0d", p, load_index5, load5, seq[p]); end
        p++;
      end
    end
    checks++; if (load_data5 !== rom_fn(22'h05001)) begin errors++; $display("FAIL wrap5_data got=%h exp=%h", load_data5, rom_fn(22'h05001)); end
  endtask

`ifdef TILE_ROM_FETCH_CACHE_EN
  task automatic test_cache();
    logic ok; int cyc, t0;
    tick();
    ch_addr4[0*AW +: AW] = 22'h00100;
    t0 = toggles4;
    ch_req4[0] = ~ch_req4[0];
    wait_load4(30, ok, cyc);
    checks++; if (!ok || toggles4 - t0 !== 1 || load_data4 !== rom_fn(22'h00100)) begin
      errors++; $display("FAIL cache_first toggles=%0d data=%h exp 1/%h", toggles4 - t0, load_data4, rom_fn(22'h00100)); end
    tick();
    t0 = toggles4;
    ch_req4[0] = ~ch_req4[0];
    wait_load4(30, ok, cyc);
    checks++; if (!ok || cyc !== 2 || toggles4 - t0 !== 0) begin errors++; $display("FAIL cache_hit latency=%0d toggles=%0d exp 2/0", cyc, toggles4 - t0); end
    checks++; if (load4 !== 4'b0001 || load_data4 !== rom_fn(22'h00100)) begin errors++; $display("FAIL cache_hit_data load=%b data=%h", load4, load_data4); end
    tick();
    ch_addr4[0*AW +: AW] = 22'h00200;
    t0 = toggles4;
    ch_req4[0] = ~ch_req4[0];
    wait_load4(30, ok, cyc);
    checks++; if (!ok || toggles4 - t0 !== 1) begin errors++; $display("FAIL cache_other toggles=%0d exp=1", toggles4 - t0); end
    tick();
    ch_addr4[0*AW +: AW] = 22'h00100;
    t0 = toggles4;
    ch_req4[0] = ~ch_req4[0];
    wait_load4(30, ok, cyc);
    checks++; if (!ok || cyc !== 6 || toggles4 - t0 !== 1 || load_data4 !== rom_fn(22'h00100)) begin
      errors++; $display("FAIL cache_evicted latency=%0d toggles=%0d data=%h exp 6/1", cyc, toggles4 - t0, load_data4); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_blank();
    test_back_to_back();
    test_reset_mid();
    test_wrap5();
`ifdef TILE_ROM_FETCH_CACHE_EN
    test_cache();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
